// File: rtl/sgdsp_pkg.sv
// Shared definitions for the sgdsp sigma-delta path: accumulator width
// helper, output buffer states and CIC priming depth.
package sgdsp_pkg;

    // The first two comb outputs after reset carry the start-up transient.
    localparam int unsigned PRIME_N = 2;

    typedef enum logic {
        EMPTY,
        FULL
    } buf_state_e;

    // Second-order CIC with R = 2^dec_log2 grows by 2*dec_log2 bits over one input bit.
    function automatic int unsigned acc_width(input int unsigned dec_log2);
        return 2 * dec_log2 + 1;
    endfunction

endpackage

// File: rtl/sgdsp_strobe_gen.sv
// Bit-rate strobe generator: one-cycle pulse every MAX_COUNT+1 clocks.
// Shared by the modulator and decimator so both ends agree on the bit rate.
module sgdsp_strobe_gen #(
    parameter int unsigned COUNT_WIDTH = 4,
    parameter int unsigned MAX_COUNT   = 6
) (
    input  logic CLK_i,
    input  logic RST_i,
    output logic strobe_o
);

    logic [COUNT_WIDTH-1:0] cnt_q;

    assign strobe_o = (cnt_q == COUNT_WIDTH'(MAX_COUNT));

    // Free-running counter 0..MAX_COUNT, wrapping on the strobe cycle.
    always_ff @(posedge CLK_i) begin
        if (RST_i) begin
            cnt_q <= '0;
        end else if (strobe_o) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

endmodule

// File: rtl/sgdsp_decimator.sv
// Receive side of the sgdsp path: second-order CIC decimator turning a
// 1-bit PDM stream into multi-bit samples behind a valid/ready buffer.
// Build option: define SGDSP_SIGNED_OUT_EN to emit two's-complement samples
// centred on zero (c2 - R^2/2) instead of the unsigned ones count.
module sgdsp_decimator
    import sgdsp_pkg::*;
#(
    parameter int unsigned COUNT_WIDTH = 4,
    parameter int unsigned MAX_COUNT   = 6,
    parameter int unsigned DEC_LOG2    = 5
) (
    input  logic                  CLK_i,
    input  logic                  RST_i,
    input  logic                  PDM_i,
    output logic [2*DEC_LOG2:0]   SAMPLE_o,
    output logic                  VALID_o,
    input  logic                  READY_i,
    output logic                  OVERRUN_o
);

    localparam int unsigned ACC_W = acc_width(DEC_LOG2);

    logic              strobe;
    logic              pdm_s1_q, pdm_s2_q;
    logic [ACC_W-1:0]  i1_q, i2_q, i1_new, i2_new;
    logic [DEC_LOG2-1:0] dcnt_q;
    logic              dec_evt_q;
    logic [ACC_W-1:0]  i2_dly_q, c1_dly_q, c1, c2, sample_val;
    logic [1:0]        prime_q;
    logic              primed, new_sample;
    buf_state_e        state_q;
    logic [ACC_W-1:0]  sample_q;
    logic              valid_q, overrun_q;

    sgdsp_strobe_gen #(
        .COUNT_WIDTH (COUNT_WIDTH),
        .MAX_COUNT   (MAX_COUNT)
    ) u_strobe (
        .CLK_i    (CLK_i),
        .RST_i    (RST_i),
        .strobe_o (strobe)
    );

    // Two-flop synchronizer for the asynchronous pin.
    always_ff @(posedge CLK_i) begin
        if (RST_i) begin
            pdm_s1_q <= 1'b0;
            pdm_s2_q <= 1'b0;
        end else begin
            pdm_s1_q <= PDM_i;
            pdm_s2_q <= pdm_s1_q;
        end
    end

    // Integrator and comb arithmetic; all wrap modulo 2^ACC_W by design.
    always_comb begin
        i1_new = i1_q + ACC_W'(pdm_s2_q);
        i2_new = i2_q + i1_new;
        c1     = i2_q - i2_dly_q;
        c2     = c1 - c1_dly_q;
`ifdef SGDSP_SIGNED_OUT_EN
        sample_val = c2 - ACC_W'(1 << (2 * DEC_LOG2 - 1));
`else
        sample_val = c2;
`endif
    end

    assign primed     = (prime_q == 2'(PRIME_N));
    assign new_sample = dec_evt_q && primed;

    // Integrators and decimation counter advance on strobe cycles only.
    always_ff @(posedge CLK_i) begin
        if (RST_i) begin
            i1_q      <= '0;
            i2_q      <= '0;
            dcnt_q    <= '0;
            dec_evt_q <= 1'b0;
        end else begin
            dec_evt_q <= strobe && (dcnt_q == '1);
            if (strobe) begin
                i1_q   <= i1_new;
                i2_q   <= i2_new;
                dcnt_q <= dcnt_q + 1'b1;
            end
        end
    end

    // Comb delays and priming run the cycle after the decimation event,
    // once i2 holds its post-update value.
    always_ff @(posedge CLK_i) begin
        if (RST_i) begin
            i2_dly_q <= '0;
            c1_dly_q <= '0;
            prime_q  <= '0;
        end else if (dec_evt_q) begin
            i2_dly_q <= i2_q;
            c1_dly_q <= c1;
            if (!primed) begin
                prime_q <= prime_q + 1'b1;
            end
        end
    end

    // Single-entry output buffer; a new sample always wins, flagging overrun
    // only when the previous one was never accepted.
    always_ff @(posedge CLK_i) begin
        if (RST_i) begin
            state_q   <= EMPTY;
            sample_q  <= '0;
            valid_q   <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            unique case (state_q)
                EMPTY: begin
                    if (new_sample) begin
                        sample_q <= sample_val;
                        valid_q  <= 1'b1;
                        state_q  <= FULL;
                    end
                end
                FULL: begin
                    if (new_sample) begin
                        sample_q <= sample_val;
                        valid_q  <= 1'b1;
                        if (!READY_i) begin
                            overrun_q <= 1'b1;
                        end
                    end else if (READY_i) begin
                        valid_q <= 1'b0;
                        state_q <= EMPTY;
                    end
                end
                default: begin
                    state_q <= EMPTY;
                    valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign SAMPLE_o  = sample_q;
    assign VALID_o   = valid_q;
    assign OVERRUN_o = overrun_q;

endmodule

// File: tb/tb_sgdsp_decimator.sv
// Directed bench for sgdsp_decimator (default unsigned build).
// Cycle numbers count rising edges after the edge that samples reset.
module tb_sgdsp_decimator;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        pdm = 1'b0;
    logic        ready = 1'b1;
    logic [10:0] sample;
    logic        valid;
    logic        overrun;

    int unsigned cyc = 0;
    int unsigned n_cmp = 0;
    int unsigned n_fail = 0;
    logic        tog_en = 1'b0;

    always #5 clk = ~clk;

    sgdsp_decimator #(
        .COUNT_WIDTH (4),
        .MAX_COUNT   (6),
        .DEC_LOG2    (5)
    ) dut (
        .CLK_i     (clk),
        .RST_i     (rst),
        .PDM_i     (pdm),
        .SAMPLE_o  (sample),
        .VALID_o   (valid),
        .READY_i   (ready),
        .OVERRUN_o (overrun)
    );

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
        if (tog_en && (cyc % 7 == 0)) pdm = ~pdm;
    endtask

    task automatic run_to(input int unsigned n);
        while (cyc < n) tick();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        cyc = 0;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    initial begin
        // Constant ones, consumer always ready.
        pdm   = 1'b1;
        ready = 1'b1;
        do_reset();
        check("rst_valid", 32'(valid), 0);
        check("rst_sample", 32'(sample), 0);
        check("rst_overrun", 32'(overrun), 0);

        run_to(672);
        check("ones_not_yet_valid", 32'(valid), 0);
        run_to(673);
        check("ones_first_valid", 32'(valid), 1);
        check("ones_first_sample", 32'(sample), 1024);
        run_to(674);
        check("ones_consumed", 32'(valid), 0);
        run_to(896);
        check("ones_gap", 32'(valid), 0);
        run_to(897);
        check("ones_second_valid", 32'(valid), 1);
        check("ones_second_sample", 32'(sample), 1024);

        // Hold off the consumer across the next load to force an overrun.
        ready = 1'b0;
        run_to(1120);
        check("hold_valid", 32'(valid), 1);
        check("hold_no_overrun", 32'(overrun), 0);
        run_to(1121);
        check("ovr_valid", 32'(valid), 1);
        check("ovr_sample", 32'(sample), 1024);
        check("ovr_flag", 32'(overrun), 1);
        ready = 1'b1;
        run_to(1122);
        check("ovr_drained", 32'(valid), 0);
        check("ovr_sticky", 32'(overrun), 1);
        run_to(1345);
        check("ovr_next_valid", 32'(valid), 1);

        // One-cycle reset mid-stream while a sample is pending.
        do_reset();
        check("mid_rst_valid", 32'(valid), 0);
        check("mid_rst_sample", 32'(sample), 0);
        check("mid_rst_overrun", 32'(overrun), 0);
        run_to(672);
        check("mid_rst_reprime", 32'(valid), 0);
        run_to(673);
        check("mid_rst_first", 32'(valid), 1);
        check("mid_rst_sample1", 32'(sample), 1024);

        // Ready rises in exactly the cycle the next sample is loaded.
        ready = 1'b0;
        run_to(896);
        check("same_pre_valid", 32'(valid), 1);
        ready = 1'b1;
        run_to(897);
        check("same_valid", 32'(valid), 1);
        check("same_sample", 32'(sample), 1024);
        check("same_no_overrun", 32'(overrun), 0);
        run_to(898);
        check("same_consumed", 32'(valid), 0);

        // Constant zeros.
        pdm = 1'b0;
        do_reset();
        run_to(673);
        check("zeros_valid", 32'(valid), 1);
        check("zeros_sample", 32'(sample), 0);
        run_to(897);
        check("zeros_sample2", 32'(sample), 0);

        // Alternating bits, one toggle per bit period.
        pdm    = 1'b0;
        tog_en = 1'b1;
        do_reset();
        run_to(673);
        check("alt_valid", 32'(valid), 1);
        check("alt_sample", 32'(sample), 512);
        run_to(897);
        check("alt_valid2", 32'(valid), 1);
        check("alt_sample2", 32'(sample), 512);
        run_to(1121);
        check("alt_sample3", 32'(sample), 512);
        tog_en = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/sgdsp_decimator.md
Name: sgdsp_decimator

Overview:
- Receive side of the sgdsp sigma-delta path: takes a 1-bit sigma-delta/PDM stream from a PMOD pin and reconstructs multi-bit samples.
- Uses a second-order CIC decimator.
- Bit-rate strobe uses the same COUNT_WIDTH/MAX_COUNT scheme as the modulator, so both ends run at the same bit rate.
- Output is a buffered sample with a valid/ready handshake toward downstream DSP or a UART.

Parameters:
- COUNT_WIDTH, 4: width of the bit-rate strobe counter.
- MAX_COUNT, 6: strobe counter terminal value; bit period = MAX_COUNT+1 clocks.
- DEC_LOG2, 5: log2 of the decimation ratio R (R = 2^DEC_LOG2 = 32).

Ports:
- CLK_i  in  1  system clock (12 MHz on Icestick).
- RST_i  in  1  synchronous, active-high reset.
- PDM_i  in  1  asynchronous 1-bit stream from the PMOD pin.
- SAMPLE_o  out  2*DEC_LOG2+1  decimated sample (ACC_W bits, 11 at default).
- VALID_o  out  1  SAMPLE_o holds an unconsumed sample.
- READY_i  in  1  consumer accepts the sample when VALID_o && READY_i.
- OVERRUN_o  out  1  sticky flag: a sample was overwritten before it was accepted.

Behaviour:
- Reset:
  - Synchronous and active-high; takes effect on the next CLK_i edge, including mid-operation.
  - Clears the synchronizer, strobe counter, decimation counter, integrators, comb delays and priming counter.
  - SAMPLE_o=0, VALID_o=0, OVERRUN_o=0. Buffer returns to EMPTY and priming restarts.
- Input path:
  - 2-flop synchronizer on PDM_i.
  - The synchronized bit is used only on strobe cycles.
- Strobe:
  - Counter runs 0..MAX_COUNT; strobe=1 in the cycle the counter equals MAX_COUNT, then it wraps to 0.
  - Period = MAX_COUNT+1 = 7 clocks.
- Integrators (updated on strobe only):
  - i1 += bit, where bit 1→1 and 0→0.
  - i2 += i1_new.
  - Both are ACC_W bits, modulo 2^ACC_W; wrap is intentional and correct for CIC.
- Decimation:
  - dcnt (DEC_LOG2 bits) increments on each strobe.
  - The strobe where dcnt==R-1 is the decimation event, cycle T.
- Comb (cycle T+1, uses post-update i2):
  - c1 = i2 - i2_d; c2 = c1 - c1_d, both mod 2^ACC_W.
  - Then i2_d←i2 and c1_d←c1.
- Priming:
  - The first 2 comb outputs after reset are discarded.
  - A 2-bit prime counter saturates at 2.
- Output buffer FSM (states EMPTY, FULL); a new comb result is loaded at T+2:
  - EMPTY + new: load SAMPLE_o, VALID_o=1 at T+2, go to FULL.
  - FULL + READY_i, no new: VALID_o=0, go to EMPTY.
  - FULL + READY_i + new in the same cycle: old sample is consumed, new one loaded, stay FULL, no overrun.
  - FULL + !READY_i + new: overwrite with the newest sample and set OVERRUN_o, which stays set until reset.
  - SAMPLE_o is stable while VALID_o && !READY_i, except on overwrite.
- Range:
  - Steady-state output = number of ones in the last R bits, convolved twice, i.e. 0..R^2.
  - R^2 = 1024 at default, which fits ACC_W = 11 unsigned.
- Throughput: one sample per R*(MAX_COUNT+1) = 224 clocks.

Optional Feature:
- Macro: SGDSP_SIGNED_OUT_EN.
- Defined: SAMPLE_o = c2 - R^2/2 as two's complement, range -512..+512 at default.
- Undefined: SAMPLE_o = c2, unsigned.
- Handshake, latency and overrun behaviour are identical in both builds.

Decomposition:
- Package sgdsp_pkg holds:
  - Function acc_width(dec_log2) = 2*dec_log2+1.
  - Buffer state enum {EMPTY, FULL}.
  - Priming depth constant PRIME_N = 2.
- Sub-module sgdsp_strobe_gen (COUNT_WIDTH, MAX_COUNT; CLK_i, RST_i → strobe_o), shared with the modulator side.

Test Plan:
- Hold PDM_i=1, READY_i=1:
  - First VALID_o is the third decimation event + 2 clocks, with SAMPLE_o=1024.
  - Every following sample is 1024, spaced 224 clocks apart.
  - Signed build: 512.
- Hold PDM_i=0 → all samples 0 (signed build: -512).
- Toggle PDM_i every bit period (1010…) → steady SAMPLE_o=512 (signed build: 0).
- Hold READY_i=0 across two decimation events with PDM_i=1:
  - VALID_o stays 1 and SAMPLE_o holds the newest sample.
  - OVERRUN_o=1 from the cycle of the second load and remains set after READY_i rises.
- Raise READY_i in exactly the cycle a new sample loads → new sample latched, VALID_o stays 1, OVERRUN_o stays 0.
- Assert RST_i for 1 cycle mid-stream:
  - Next cycle: VALID_o=0, SAMPLE_o=0, OVERRUN_o=0.
  - The next valid sample appears only after 3 fresh decimation events.
